// File: rtl/dm_bridge_pkg.sv
// dm_bridge_pkg: shared constants and types for the data-memory bridge.
//   - RAM decode limit and timer register word offsets
//   - CTRL register bit positions and MODE encodings
//   - timer FSM state enum
package dm_bridge_pkg;

  localparam logic [31:0] RAM_LIMIT = 32'h0000_3000;

  // Timer register word offsets relative to TC_BASE
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;
  localparam int unsigned CTRL_W       = 4;

  // MODE encodings; the two unused codes behave as one-shot
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01
  } tc_mode_e;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer (CTRL / PRESET / COUNT) with FSM.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   wr_en            - accepted full-word write strobe (already decoded)
//   off              - register word offset for both read and write
//   wr_data          - write data
//   rd_data          - combinational register read data for off
//   irq              - irq_flag gated by CTRL.IM
module tc_timer
  import dm_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  off,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [31:0]        preset_q, preset_d;
  logic [31:0]        count_q, count_d;
  logic               flag_q, flag_d;

  logic ctrl_wr, preset_wr, enter_int, en, reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    flag_d    = flag_q;
    enter_int = 1'b0;

    ctrl_wr   = wr_en && (off == OFF_CTRL);
    preset_wr = wr_en && (off == OFF_PRESET);
    en        = ctrl_q[CTRL_EN];
    reload    = tc_mode_e'(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]) == MODE_RELOAD;

    unique case (state_q)
      TC_IDLE: if (en) state_d = TC_LOAD;
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!en) begin
          state_d = TC_IDLE;
        end else if (count_q == '0) begin
          state_d   = TC_INT;
          enter_int = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      TC_INT: begin
        state_d = TC_IDLE;
        if (!reload) ctrl_d[CTRL_EN] = 1'b0;
      end
      default: state_d = TC_IDLE;
    endcase

    // Ordering matters: a CTRL write overrides the FSM's EN clear, and
    // entry into INT overrides a same-edge flag clear.
    if (ctrl_wr)   ctrl_d   = wr_data[CTRL_W-1:0];
    if (preset_wr) preset_d = wr_data;
    if (ctrl_wr || preset_wr) flag_d = 1'b0;
    if (enter_int) flag_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    unique case (off)
      OFF_CTRL:   rd_data = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: rd_data = preset_q;
      OFF_COUNT:  rd_data = count_q;
      default:    rd_data = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/dm_bridge.sv
// dm_bridge: memory-side responder for the CPU data port. Decodes each
// address to the data RAM or to the countdown timer; unmapped accesses read 0
// and writes to them are dropped.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   m_data_addr     - byte address (bits [1:0] ignored)
//   m_data_wdata    - lane-aligned write data
//   m_data_byteen   - per-lane write enable, 0 = read/idle
//   m_data_rdata    - combinational read data
//   irq             - timer interrupt (level)
module dm_bridge
  import dm_bridge_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 3072,
  parameter logic [31:0] TC_BASE   = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] ram_word_d;
  logic [11:0] ram_idx;
  logic        ram_hit, ram_we;
  logic [29:0] tc_word;
  logic [1:0]  tc_off;
  logic        tc_hit, tc_wr;
  logic [31:0] tc_rdata;

  always_comb begin
    ram_idx = m_data_addr[13:2];
    ram_hit = m_data_addr < RAM_LIMIT;
    ram_we  = ram_hit && (m_data_byteen != '0);

    // Word distance from the timer base; addresses below the base wrap to a
    // large value and therefore miss.
    tc_word = m_data_addr[31:2] - TC_BASE[31:2];
    tc_hit  = tc_word < 30'd3;
    tc_off  = tc_word[1:0];
    tc_wr   = tc_hit && (m_data_byteen == 4'b1111);

    ram_word_d = ram_q[ram_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) ram_word_d[8*i +: 8] = m_data_wdata[8*i +: 8];
    end

    if (ram_hit)     m_data_rdata = ram_q[ram_idx];
    else if (tc_hit) m_data_rdata = tc_rdata;
    else             m_data_rdata = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      ram_q[ram_idx] <= ram_word_d;
    end
  end

  tc_timer u_tc_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tc_wr),
    .off     (tc_off),
    .wr_data (m_data_wdata),
    .rd_data (tc_rdata),
    .irq     (irq)
  );

endmodule

// File: tb/tb_dm_bridge.sv
module tb_dm_bridge;

  localparam logic [31:0] A_CTRL   = 32'h7F00;
  localparam logic [31:0] A_PRESET = 32'h7F04;
  localparam logic [31:0] A_COUNT  = 32'h7F08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_data_rdata;
  logic        irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  dm_bridge #(.RAM_WORDS(3072), .TC_BASE(32'h7F00)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    step();
    m_data_byteen = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    chk(tag, m_data_rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    rd("rst_ram0", 32'h0000, 32'h0);
    rd("rst_ramtop", 32'h2FFC, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Byte-lane merge
    wr(32'h0010, 32'h1234_5678, 4'b1111);
    rd("ram_word", 32'h0010, 32'h1234_5678);
    wr(32'h0010, 32'h00AB_0000, 4'b0100);
    rd("ram_lane2", 32'h0010, 32'h12AB_5678);
    wr(32'h0010, 32'h0000_00EF, 4'b0001);
    rd("ram_lane0", 32'h0010, 32'h12AB_56EF);

    // Unmapped accesses
    wr(32'h0000, 32'hCAFE_F00D, 4'b1111);
    wr(32'h3000, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h7F10, 32'hDEAD_BEEF, 4'b1111);
    rd("unmap_3000", 32'h3000, 32'h0);
    rd("unmap_7f10", 32'h7F10, 32'h0);
    rd("ram0_kept", 32'h0000, 32'hCAFE_F00D);
    rd("ramtop_kept", 32'h2FFC, 32'h0);

    // One-shot, PRESET=3
    wr(A_PRESET, 32'd3, 4'b1111);
    rd("preset_rd", A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9, 4'b1111);                  // E0
    step(); step();                              // E2
    rd("os_cnt_e2", A_COUNT, 32'd3);
    step(); rd("os_cnt_e3", A_COUNT, 32'd2);
    step(); rd("os_cnt_e4", A_COUNT, 32'd1);
    step(); rd("os_cnt_e5", A_COUNT, 32'd0);
    chk_irq("os_irq_e5", 1'b0);
    step();                                      // E6
    chk_irq("os_irq_e6", 1'b1);
    rd("os_ctrl_e6", A_CTRL, 32'h9);
    step();                                      // E7
    rd("os_ctrl_e7", A_CTRL, 32'h8);
    chk_irq("os_irq_e7", 1'b1);
    step(); step();
    chk_irq("os_irq_hold", 1'b1);
    wr(A_COUNT, 32'h1234, 4'b1111);
    rd("count_ro", A_COUNT, 32'd0);
    chk_irq("os_irq_cntwr", 1'b1);
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET=2, period 6
    wr(A_PRESET, 32'd2, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);                  // E0
    repeat (4) step();                           // E4
    chk_irq("ar_irq_e4", 1'b0);
    step();                                      // E5
    chk_irq("ar_irq_e5", 1'b1);
    wr(A_CTRL, 32'hB, 4'b1111);                  // E6, clears flag
    chk_irq("ar_irq_e6", 1'b0);
    repeat (4) step();                           // E10
    chk_irq("ar_irq_e10", 1'b0);
    rd("ar_cnt_e10", A_COUNT, 32'd0);
    step();                                      // E11
    chk_irq("ar_irq_e11", 1'b1);
    rd("ar_ctrl_kept", A_CTRL, 32'hB);

    // Async reset mid-count
    wr(A_CTRL, 32'h0, 4'b1111);
    wr(A_PRESET, 32'd10, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);                  // E0
    step(); step();                              // E2: COUNT=10
    repeat (5) step();                           // E7: COUNT=5
    rd("pre_rst_cnt", A_COUNT, 32'd5);
    reset = 1'b1;
    #1;
    rd("arst_cnt", A_COUNT, 32'd0);
    chk_irq("arst_irq", 1'b0);
    rd("arst_ctrl", A_CTRL, 32'h0);
    rd("arst_preset", A_PRESET, 32'h0);
    rd("arst_ram", 32'h0010, 32'h0);
    reset = 1'b0;

    // Partial timer write ignored; restart from IDLE
    step();
    wr(A_PRESET, 32'd2, 4'b1111);
    wr(A_PRESET, 32'h55, 4'b0011);
    rd("preset_partial", A_PRESET, 32'd2);
    wr(A_CTRL, 32'h5, 4'b0001);
    rd("ctrl_partial", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h9, 4'b1111);                  // E0
    step();                                      // E1
    rd("post_rst_e1", A_COUNT, 32'd0);
    step();                                      // E2
    rd("post_rst_e2", A_COUNT, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Memory-side responder for the CPU data port: serves the M-stage load/store requests (`m_data_addr`, `m_data_wdata`, `m_data_byteen`) and returns `m_data_rdata`. It decodes each address to a 3072-word data RAM or to a memory-mapped countdown timer that raises an interrupt line. It sits outside the pipelined core, between the CPU's data port and the memories and peripherals.

## Interface
Parameters:
- `RAM_WORDS`, 3072: data RAM depth in 32-bit words, at byte addresses 0x0000–0x2FFF.
- `TC_BASE`, 32'h7F00: timer register base address.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `m_data_addr` in 32: byte address; bits [1:0] are ignored for decode.
- `m_data_wdata` in 32: write data, already lane-aligned by the core.
- `m_data_byteen` in 4: per-lane write enable; 4'b0000 means read or idle.
- `m_data_rdata` out 32: combinational read data for `m_data_addr`.
- `irq` out 1: timer interrupt, level-sensitive.

## Operation
- Decode:
  - RAM when addr < 0x3000.
  - CTRL at `TC_BASE`+0, PRESET at +4, COUNT at +8 (read-only).
  - Anything else is unmapped: reads return 0, writes are ignored.
- RAM writes:
  - Every lane i with `m_data_byteen[i]`=1 writes byte `wdata[8i+7:8i]` at the edge.
  - Other lanes are unchanged.
  - Index is addr[13:2].
- Timer writes:
  - Accepted only with byteen=4'b1111.
  - Partial writes to timer addresses are ignored.
  - Writes to COUNT are ignored.
- CTRL fields: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, others behave as one-shot), bit3 IM (interrupt mask). Bits [31:4] read as 0.
- Timer FSM:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT←PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE (COUNT holds). Else if COUNT=0, go to INT. Else COUNT←COUNT−1.
  - INT: set irq_flag, go to IDLE. In one-shot mode, also clear EN.
- `irq` = irq_flag & IM.
  - irq_flag is cleared by any accepted write to CTRL or PRESET.
  - If a clearing write and entry into INT fall on the same edge, the flag ends up set.
- A CTRL write on the same edge as the FSM clearing EN: the written value wins.
- Writing PRESET during CNT does not affect COUNT until the next LOAD.
- COUNT arithmetic is 32-bit unsigned; it never wraps below 0.

## Timing
- Reads: zero latency, combinational from `m_data_addr`, including timer registers. They reflect state after the last edge.
- A store to an address followed by a load from the same address in the next cycle returns the new data. There is no bypass within the same cycle.
- Reset values:
  - RAM all 0.
  - CTRL, PRESET, COUNT = 0; state = IDLE; irq_flag = 0.
  - `irq` = 0; `m_data_rdata` = 0 for all mapped addresses.
- Reset asserted mid-count forces the reset values immediately, without waiting for a clock edge.
- Countdown latency, with EN written at edge E0:
  - LOAD at E1, COUNT=PRESET at E2.
  - COUNT decrements on each edge, reaching 0 at E(2+PRESET).
  - INT at E(3+PRESET); `irq` visible after that edge.
- PRESET=0: INT at E3.
- Auto-reload: IDLE at E(4+P), LOAD at E(5+P). The period is P+4 cycles.

## Structure
- Shared package `dm_bridge_pkg` holds:
  - address constants (RAM limit, CTRL/PRESET/COUNT offsets);
  - CTRL bit positions;
  - MODE encodings;
  - the timer state enum (IDLE, LOAD, CNT, INT).
- One sub-module, `tc_timer`: register file plus FSM. Its inputs are a write strobe, word offset and write data; its outputs are register read data and `irq`.
- RAM storage and decode stay in `dm_bridge`.

## Test plan
- Reset, then read 0x0000, 0x2FFC, 0x7F00 → all 0. `irq`=0.
- Store word 0x12345678 at 0x0010. Store byteen=4'b0100 data 0x00AB0000 at 0x0010. Read 0x0010 → 0x12AB5678.
- Store to 0x3000 and to 0x7F10, then read both → 0. RAM word 0 is unaffected.
- PRESET=3, then CTRL=0x9 (EN, one-shot, IM) at edge E0 → COUNT reads 3,2,1,0 after E2–E5; `irq` rises after E6; CTRL reads 0x8 after E7; `irq` stays 1 until a CTRL write.
- PRESET=2, CTRL=0xB (auto-reload) → `irq` flag set after E5. A CTRL write of 0xB clears it. It sets again after E11 (period 6).
- Assert `reset` asynchronously while COUNT=5 → COUNT=0, `irq`=0, state IDLE before the next edge. A partial-byteen write to PRESET is ignored.
